centroid_coord_mapper: RTL and testbench



---
 rtl/coord_map_pkg.sv | 23 ++
 rtl/axis_coord_map.sv | 79 +++++++
 rtl/centroid_coord_mapper.sv | 171 +++++++++++++++++
 tb/tb_centroid_coord_mapper.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coord_map_pkg.sv
// Shared types and helpers for the centroid coordinate mapper.
package coord_map_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DIV,
        MAP,
        HOLD,
        WAIT_CLR
    } state_e;

    localparam int OUT_W_DEF    = 24;
    localparam int OUT_FRAC_DEF = 8;

    function automatic logic signed [31:0] clamp(input logic signed [31:0] v,
                                                 input logic signed [31:0] lo,
                                                 input logic signed [31:0] hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/axis_coord_map.sv
// One axis: slice the quotient, apply gain/offset/clamp, optional exponential
// smoothing, and register the fixed-point coordinate on load_i.
module axis_coord_map
    import coord_map_pkg::*;
#(
    parameter int DIV_W       = 32,
    parameter int FRAC        = 2,
    parameter int INT_W       = 10,
    parameter int GAIN_SHIFT  = 1,
    parameter int OFFSET      = -640,
    parameter int MIN_V       = -640,
    parameter int MAX_V       = 640,
    parameter int ALPHA_SHIFT = 0,
    parameter int OUT_W       = OUT_W_DEF,
    parameter int OUT_FRAC    = OUT_FRAC_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DIV_W-1:0]        q_i,
    input  logic                    load_i,
    output logic signed [OUT_W-1:0] coord_o
);

    localparam int OFF_MAG = (OFFSET < 0) ? -OFFSET : OFFSET;
    localparam int MW      = INT_W + GAIN_SHIFT + 2 + $clog2(OFF_MAG + 1);
    // One extra bit so the filter difference never overflows.
    localparam int FW      = MW + 1;

    logic [INT_W-1:0]        int_part;
    logic signed [MW-1:0]    mapped;
    logic signed [31:0]      clamped32;
    logic signed [MW-1:0]    clamped;
    logic signed [FW-1:0]    c_w;
    logic signed [FW-1:0]    f_w;
    logic signed [FW-1:0]    step;
    logic signed [FW-1:0]    sum;
    logic signed [MW-1:0]    f_q;
    logic signed [MW-1:0]    f_d;
    logic                    primed_q;
    logic signed [OUT_W-1:0] f_ext;
    logic signed [OUT_W-1:0] coord_q;
    logic signed [OUT_W-1:0] coord_d;
    logic                    unused_q_bits;

    assign unused_q_bits = ^q_i;

    always_comb begin
        int_part  = q_i[FRAC+INT_W-1:FRAC];
        mapped    = $signed({{(MW-INT_W){1'b0}}, int_part} << GAIN_SHIFT) + MW'(OFFSET);
        clamped32 = clamp(32'(mapped), MIN_V, MAX_V);
        clamped   = clamped32[MW-1:0];
        c_w       = FW'(clamped);
        f_w       = FW'(f_q);
        step      = (c_w - f_w) >>> ALPHA_SHIFT;
        sum       = f_w + step;
        if (ALPHA_SHIFT == 0 || !primed_q) begin
            f_d = clamped;
        end else begin
            f_d = sum[MW-1:0];
        end
        f_ext   = OUT_W'(f_d);
        coord_d = f_ext <<< OUT_FRAC;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_q      <= '0;
            primed_q <= 1'b0;
            coord_q  <= '0;
        end else if (load_i) begin
            f_q      <= f_d;
            primed_q <= 1'b1;
            coord_q  <= coord_d;
        end
    end

    assign coord_o = coord_q;

endmodule

// File: rtl/centroid_coord_mapper.sv
// Captures x/y divider quotients once per accumulation pass and presents the
// mapped coordinate pair over a valid/ready handshake.
module centroid_coord_mapper
    import coord_map_pkg::*;
#(
    parameter int DIV_W        = 32,
    parameter int X_FRAC       = 2,
    parameter int X_INT_W      = 10,
    parameter int X_GAIN_SHIFT = 1,
    parameter int X_OFFSET     = -640,
    parameter int X_MIN        = -640,
    parameter int X_MAX        = 640,
    parameter int Y_FRAC       = 3,
    parameter int Y_INT_W      = 8,
    parameter int Y_GAIN_SHIFT = 0,
    parameter int Y_OFFSET     = 700,
    parameter int Y_MIN        = 0,
    parameter int Y_MAX        = 1023,
    parameter int OUT_W        = OUT_W_DEF,
    parameter int OUT_FRAC     = OUT_FRAC_DEF,
    parameter int ALPHA_SHIFT  = 0,
    parameter int TIMEOUT_CYC  = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DIV_W-1:0]        xdiv,
    input  logic                    xdiv_valid,
    input  logic [DIV_W-1:0]        ydiv,
    input  logic                    ydiv_valid,
    input  logic                    acc_done,
    output logic signed [OUT_W-1:0] xout,
    output logic signed [OUT_W-1:0] yout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    timeout
);

    localparam int            CW     = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYC);

    state_e           state_q;
    state_e           state_d;
    logic             xflag_q;
    logic             xflag_d;
    logic             yflag_q;
    logic             yflag_d;
    logic [DIV_W-1:0] xq_q;
    logic [DIV_W-1:0] yq_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic             timeout_q;
    logic             timeout_d;
    logic             in_wait;
    logic             stay_wait;
    logic             cap_x;
    logic             cap_y;
    logic             load;
    logic             both_seen;
    logic             to_hit;

    // A valid arriving this cycle counts toward completion alongside the sticky flags.
    assign both_seen = (xflag_q | xdiv_valid) & (yflag_q | ydiv_valid);
    assign to_hit    = (TIMEOUT_CYC != 0) && ((cnt_q + 1'b1) == TO_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (acc_done) state_d = WAIT_DIV;
            WAIT_DIV: begin
                if (both_seen)      state_d = MAP;
                else if (!acc_done) state_d = IDLE;
                else if (to_hit)    state_d = WAIT_CLR;
            end
            MAP:      state_d = HOLD;
            HOLD:     if (out_ready) state_d = WAIT_CLR;
            WAIT_CLR: if (!acc_done) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        in_wait     = (state_q == WAIT_DIV);
        stay_wait   = in_wait && (state_d == WAIT_DIV);
        cap_x       = in_wait && xdiv_valid && !xflag_q;
        cap_y       = in_wait && ydiv_valid && !yflag_q;
        load        = (state_q == MAP);
        xflag_d     = stay_wait ? (xflag_q | xdiv_valid) : 1'b0;
        yflag_d     = stay_wait ? (yflag_q | ydiv_valid) : 1'b0;
        cnt_d       = stay_wait ? (cnt_q + 1'b1) : '0;
        timeout_d   = in_wait && (state_d == WAIT_CLR);
        out_valid_d = out_valid_q;
        if (load) begin
            out_valid_d = 1'b1;
        end else if (state_q == HOLD && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xflag_q     <= 1'b0;
            yflag_q     <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            xflag_q     <= xflag_d;
            yflag_q     <= yflag_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cap_x) xq_q <= xdiv;
        if (cap_y) yq_q <= ydiv;
    end

    axis_coord_map #(
        .DIV_W      (DIV_W),
        .FRAC       (X_FRAC),
        .INT_W      (X_INT_W),
        .GAIN_SHIFT (X_GAIN_SHIFT),
        .OFFSET     (X_OFFSET),
        .MIN_V      (X_MIN),
        .MAX_V      (X_MAX),
        .ALPHA_SHIFT(ALPHA_SHIFT),
        .OUT_W      (OUT_W),
        .OUT_FRAC   (OUT_FRAC)
    ) u_x (
        .clk    (clk),
        .rst    (rst),
        .q_i    (xq_q),
        .load_i (load),
        .coord_o(xout)
    );

    axis_coord_map #(
        .DIV_W      (DIV_W),
        .FRAC       (Y_FRAC),
        .INT_W      (Y_INT_W),
        .GAIN_SHIFT (Y_GAIN_SHIFT),
        .OFFSET     (Y_OFFSET),
        .MIN_V      (Y_MIN),
        .MAX_V      (Y_MAX),
        .ALPHA_SHIFT(ALPHA_SHIFT),
        .OUT_W      (OUT_W),
        .OUT_FRAC   (OUT_FRAC)
    ) u_y (
        .clk    (clk),
        .rst    (rst),
        .q_i    (yq_q),
        .load_i (load),
        .coord_o(yout)
    );

    assign out_valid = out_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_centroid_coord_mapper.sv
// Bench for centroid_coord_mapper: a default instance (A) and a smoothing +
// short-timeout instance (B) share stimulus and are checked against a model.
module tb_centroid_coord_mapper;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] xdiv, ydiv;
    logic        xdiv_valid, ydiv_valid, acc_done, out_ready;
    logic [23:0] a_xout, a_yout, b_xout, b_yout;
    logic        a_valid, a_timeout, b_valid, b_timeout;

    int tests = 0;
    int fails = 0;

    int a_fx, a_fy, b_fx, b_fy;
    bit b_pr;

    always #5 clk = ~clk;

    centroid_coord_mapper u_a (
        .clk(clk), .rst(rst), .xdiv(xdiv), .xdiv_valid(xdiv_valid),
        .ydiv(ydiv), .ydiv_valid(ydiv_valid), .acc_done(acc_done),
        .xout(a_xout), .yout(a_yout), .out_valid(a_valid),
        .out_ready(out_ready), .timeout(a_timeout)
    );

    centroid_coord_mapper #(.ALPHA_SHIFT(2), .TIMEOUT_CYC(16)) u_b (
        .clk(clk), .rst(rst), .xdiv(xdiv), .xdiv_valid(xdiv_valid),
        .ydiv(ydiv), .ydiv_valid(ydiv_valid), .acc_done(acc_done),
        .xout(b_xout), .yout(b_yout), .out_valid(b_valid),
        .out_ready(out_ready), .timeout(b_timeout)
    );

    // Reference model in plain integer arithmetic.
    function automatic int lim(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int map_x(logic [31:0] q);
        int i;
        i = int'(q / 4) % 1024;
        return lim(i * 2 - 640, -640, 640);
    endfunction

    function automatic int map_y(logic [31:0] q);
        int i;
        i = int'(q / 8) % 256;
        return lim(i + 700, 0, 1023);
    endfunction

    function automatic int smooth(int prev, int c);
        int d;
        d = c - prev;
        // floor(d / 4)
        return prev + ((d >= 0) ? (d / 4) : -((-d + 3) / 4));
    endfunction

    function automatic logic [23:0] to_out(int f);
        return 24'(f * 256);
    endfunction

    task automatic model_reset();
        a_fx = 0; a_fy = 0; b_fx = 0; b_fy = 0; b_pr = 0;
    endtask

    task automatic model_pass(input logic [31:0] xq, input logic [31:0] yq,
                              output logic [23:0] eax, output logic [23:0] eay,
                              output logic [23:0] ebx, output logic [23:0] eby);
        int cx, cy;
        cx = map_x(xq);
        cy = map_y(yq);
        a_fx = cx;
        a_fy = cy;
        b_fx = b_pr ? smooth(b_fx, cx) : cx;
        b_fy = b_pr ? smooth(b_fy, cy) : cy;
        b_pr = 1;
        eax = to_out(a_fx); eay = to_out(a_fy);
        ebx = to_out(b_fx); eby = to_out(b_fy);
    endtask

    // Drives one full pass and reports what the DUTs showed; checks live in the tests.
    task automatic run_pass(input logic [31:0] xq, input logic [31:0] yq,
                            input int dx, input int dy, input int rdly,
                            output logic [23:0] ax, output logic [23:0] ay,
                            output logic [23:0] bx, output logic [23:0] by,
                            output bit lat_ok, output bit stable_ok, output bit drop_ok);
        int mx;
        mx = (dx > dy) ? dx : dy;
        @(negedge clk);
        acc_done = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        for (int t = 0; t <= mx; t++) begin
            xdiv_valid = (t == dx);
            ydiv_valid = (t == dy);
            xdiv = (t == dx) ? xq : $urandom;
            ydiv = (t == dy) ? yq : $urandom;
            @(negedge clk);
        end
        xdiv_valid = 1'b0;
        ydiv_valid = 1'b0;
        lat_ok = (a_valid === 1'b0) && (b_valid === 1'b0);
        @(negedge clk);
        lat_ok = lat_ok && (a_valid === 1'b1) && (b_valid === 1'b1);
        ax = a_xout; ay = a_yout; bx = b_xout; by = b_yout;
        stable_ok = 1'b1;
        for (int r = 0; r < rdly; r++) begin
            xdiv_valid = $urandom_range(0, 1);
            ydiv_valid = $urandom_range(0, 1);
            xdiv = $urandom;
            ydiv = $urandom;
            @(negedge clk);
            if (a_valid !== 1'b1 || b_valid !== 1'b1 || a_xout !== ax || a_yout !== ay ||
                b_xout !== bx || b_yout !== by)
                stable_ok = 1'b0;
        end
        xdiv_valid = 1'b0;
        ydiv_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        drop_ok = (a_valid === 1'b0) && (b_valid === 1'b0);
        xdiv_valid = 1'b1;
        ydiv_valid = 1'b1;
        xdiv = $urandom;
        ydiv = $urandom;
        @(negedge clk);
        xdiv_valid = 1'b0;
        ydiv_valid = 1'b0;
        acc_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (a_valid !== 1'b0 || b_valid !== 1'b0) drop_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (a_valid !== 1'b0) begin fails++; $display("FAIL reset_a_valid got %b exp 0", a_valid); end
        tests++; if (a_timeout !== 1'b0) begin fails++; $display("FAIL reset_a_timeout got %b exp 0", a_timeout); end
        tests++; if ({a_xout, a_yout} !== 48'h0) begin fails++; $display("FAIL reset_a_xy got %h %h exp 0 0", a_xout, a_yout); end
        tests++; if ({b_valid, b_timeout, b_xout, b_yout} !== 50'h0) begin fails++; $display("FAIL reset_b got %b %b %h %h exp all 0", b_valid, b_timeout, b_xout, b_yout); end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [23:0] ax, ay, bx, by, eax, eay, ebx, eby;
        bit lat, stb, drp;
        run_pass(32'h640, 32'h320, 0, 0, 0, ax, ay, bx, by, lat, stb, drp);
        model_pass(32'h640, 32'h320, eax, eay, ebx, eby);
        tests++; if (lat !== 1'b1) begin fails++; $display("FAIL basic_latency got %b exp 1", lat); end
        tests++; if (ax !== 24'h00A000) begin fails++; $display("FAIL basic_ax got %h exp 00a000", ax); end
        tests++; if (ay !== 24'h032000) begin fails++; $display("FAIL basic_ay got %h exp 032000", ay); end
        tests++; if ({bx, by} !== {ebx, eby}) begin fails++; $display("FAIL basic_b got %h %h exp %h %h", bx, by, ebx, eby); end
        tests++; if (drp !== 1'b1) begin fails++; $display("FAIL basic_one_cycle got %b exp 1", drp); end
    endtask

    task automatic test_alpha();
        logic [23:0] ax, ay, bx, by, eax, eay, ebx, eby;
        bit lat, stb, drp;
        run_pass(32'd1280, 32'h320, 0, 0, 0, ax, ay, bx, by, lat, stb, drp);
        model_pass(32'd1280, 32'h320, eax, eay, ebx, eby);
        tests++; if (bx !== 24'h007800) begin fails++; $display("FAIL alpha_bx got %h exp 007800", bx); end
        tests++; if (ax !== 24'h000000) begin fails++; $display("FAIL alpha_ax got %h exp 000000", ax); end
        tests++; if (by !== eby) begin fails++; $display("FAIL alpha_by got %h exp %h", by, eby); end
    endtask

    task automatic test_stagger();
        logic [23:0] ax, ay, bx, by, eax, eay, ebx, eby;
        logic [31:0] xq, yq;
        bit lat, stb, drp;
        xq = $urandom; yq = $urandom;
        run_pass(xq, yq, 0, 5, 10, ax, ay, bx, by, lat, stb, drp);
        model_pass(xq, yq, eax, eay, ebx, eby);
        tests++; if (lat !== 1'b1) begin fails++; $display("FAIL stagger_latency got %b exp 1", lat); end
        tests++; if (stb !== 1'b1) begin fails++; $display("FAIL stagger_hold_stable got %b exp 1", stb); end
        tests++; if ({ax, ay} !== {eax, eay}) begin fails++; $display("FAIL stagger_a got %h %h exp %h %h", ax, ay, eax, eay); end
        tests++; if ({bx, by} !== {ebx, eby}) begin fails++; $display("FAIL stagger_b got %h %h exp %h %h", bx, by, ebx, eby); end
        tests++; if (drp !== 1'b1) begin fails++; $display("FAIL stagger_drop got %b exp 1", drp); end
    endtask

    task automatic test_clamp();
        logic [23:0] ax, ay, bx, by, eax, eay, ebx, eby;
        bit lat, stb, drp;
        run_pass(32'hFA0, 32'hFFFF_FFFF, 1, 0, 0, ax, ay, bx, by, lat, stb, drp);
        model_pass(32'hFA0, 32'hFFFF_FFFF, eax, eay, ebx, eby);
        tests++; if (ax !== 24'h028000) begin fails++; $display("FAIL clamp_hi_ax got %h exp 028000", ax); end
        tests++; if (ay !== eay) begin fails++; $display("FAIL clamp_hi_ay got %h exp %h", ay, eay); end
        run_pass(32'h0, 32'h0, 0, 2, 1, ax, ay, bx, by, lat, stb, drp);
        model_pass(32'h0, 32'h0, eax, eay, ebx, eby);
        tests++; if (ax !== 24'hFD8000) begin fails++; $display("FAIL clamp_lo_ax got %h exp fd8000", ax); end
        tests++; if (ay !== 24'h02BC00) begin fails++; $display("FAIL clamp_lo_ay got %h exp 02bc00", ay); end
        tests++; if ({bx, by} !== {ebx, eby}) begin fails++; $display("FAIL clamp_lo_b got %h %h exp %h %h", bx, by, ebx, eby); end
    endtask

    task automatic test_abort();
        logic [23:0] ax, ay, bx, by, eax, eay, ebx, eby;
        logic [31:0] xq, yq;
        bit lat, stb, drp, quiet;
        @(negedge clk);
        acc_done = 1'b1;
        @(negedge clk);
        xdiv_valid = 1'b1; xdiv = $urandom;
        @(negedge clk);
        xdiv_valid = 1'b0;
        acc_done = 1'b0;
        @(negedge clk);
        ydiv_valid = 1'b1; ydiv = $urandom;
        quiet = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ydiv_valid = 1'b0;
            if (a_valid !== 1'b0 || b_valid !== 1'b0) quiet = 1'b0;
        end
        tests++; if (quiet !== 1'b1) begin fails++; $display("FAIL abort_no_output got %b exp 1", quiet); end
        xq = $urandom; yq = $urandom;
        run_pass(xq, yq, 3, 0, 0, ax, ay, bx, by, lat, stb, drp);
        model_pass(xq, yq, eax, eay, ebx, eby);
        tests++; if (lat !== 1'b1) begin fails++; $display("FAIL abort_next_latency got %b exp 1", lat); end
        tests++; if ({ax, ay} !== {eax, eay}) begin fails++; $display("FAIL abort_next_a got %h %h exp %h %h", ax, ay, eax, eay); end
    endtask

    task automatic test_timeout();
        logic [23:0] ax, ay, bx, by, eax, eay, ebx, eby;
        logic [31:0] xq, yq;
        bit lat, stb, drp, pulse_ok, quiet;
        @(negedge clk);
        acc_done = 1'b1;
        @(negedge clk);
        xdiv_valid = 1'b1; xdiv = $urandom;
        pulse_ok = 1'b1;
        quiet = 1'b1;
        for (int j = 1; j <= 22; j++) begin
            if (j > 1) @(negedge clk);
            if (j == 2) xdiv_valid = 1'b0;
            if (b_timeout !== (j == 17)) pulse_ok = 1'b0;
            if (a_timeout !== 1'b0 || a_valid !== 1'b0 || b_valid !== 1'b0) quiet = 1'b0;
        end
        xdiv_valid = 1'b0;
        tests++; if (pulse_ok !== 1'b1) begin fails++; $display("FAIL timeout_pulse got %b exp 1", pulse_ok); end
        tests++; if (quiet !== 1'b1) begin fails++; $display("FAIL timeout_quiet got %b exp 1", quiet); end
        acc_done = 1'b0;
        repeat (3) @(negedge clk);
        xq = $urandom; yq = $urandom;
        run_pass(xq, yq, 2, 0, 1, ax, ay, bx, by, lat, stb, drp);
        model_pass(xq, yq, eax, eay, ebx, eby);
        tests++; if (lat !== 1'b1) begin fails++; $display("FAIL timeout_next_latency got %b exp 1", lat); end
        tests++; if ({bx, by} !== {ebx, eby}) begin fails++; $display("FAIL timeout_next_b got %h %h exp %h %h", bx, by, ebx, eby); end
    endtask

    task automatic test_reset_hold();
        logic [23:0] ax, ay, bx, by, eax, eay, ebx, eby;
        logic [31:0] xq, yq;
        bit lat, stb, drp;
        @(negedge clk);
        acc_done = 1'b1;
        @(negedge clk);
        xdiv_valid = 1'b1; ydiv_valid = 1'b1;
        xdiv = $urandom; ydiv = $urandom;
        @(negedge clk);
        xdiv_valid = 1'b0; ydiv_valid = 1'b0;
        @(negedge clk);
        tests++; if (a_valid !== 1'b1) begin fails++; $display("FAIL rsthold_valid_before got %b exp 1", a_valid); end
        rst = 1'b1;
        acc_done = 1'b0;
        @(negedge clk);
        tests++; if ({a_valid, b_valid} !== 2'b00) begin fails++; $display("FAIL rsthold_valid got %b%b exp 00", a_valid, b_valid); end
        tests++; if ({a_xout, a_yout, b_xout, b_yout} !== 96'h0) begin fails++; $display("FAIL rsthold_xy got %h %h %h %h exp 0", a_xout, a_yout, b_xout, b_yout); end
        rst = 1'b0;
        model_reset();
        xq = $urandom; yq = $urandom;
        run_pass(xq, yq, 1, 1, 2, ax, ay, bx, by, lat, stb, drp);
        model_pass(xq, yq, eax, eay, ebx, eby);
        tests++; if ({bx, by} !== {ebx, eby}) begin fails++; $display("FAIL rsthold_next_b got %h %h exp %h %h", bx, by, ebx, eby); end
        tests++; if ({ax, ay} !== {eax, eay}) begin fails++; $display("FAIL rsthold_next_a got %h %h exp %h %h", ax, ay, eax, eay); end
    endtask

    task automatic test_random();
        logic [23:0] ax, ay, bx, by, eax, eay, ebx, eby;
        logic [31:0] xq, yq;
        bit lat, stb, drp;
        for (int n = 0; n < 20; n++) begin
            xq = $urandom; yq = $urandom;
            run_pass(xq, yq, $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 4),
                     ax, ay, bx, by, lat, stb, drp);
            model_pass(xq, yq, eax, eay, ebx, eby);
            tests++; if (lat !== 1'b1) begin fails++; $display("FAIL rand%0d_latency got %b exp 1", n, lat); end
            tests++; if (stb !== 1'b1) begin fails++; $display("FAIL rand%0d_stable got %b exp 1", n, stb); end
            tests++; if (drp !== 1'b1) begin fails++; $display("FAIL rand%0d_drop got %b exp 1", n, drp); end
            tests++; if ({ax, ay} !== {eax, eay}) begin fails++; $display("FAIL rand%0d_a got %h %h exp %h %h", n, ax, ay, eax, eay); end
            tests++; if ({bx, by} !== {ebx, eby}) begin fails++; $display("FAIL rand%0d_b got %h %h exp %h %h", n, bx, by, ebx, eby); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired exp run to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        xdiv = '0; ydiv = '0;
        xdiv_valid = 1'b0; ydiv_valid = 1'b0;
        acc_done = 1'b0; out_ready = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_alpha();
        test_stagger();
        test_clamp();
        test_abort();
        test_timeout();
        test_reset_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
